// File: rtl/opb_emu_initiator.sv
// Host-side OPB emulation initiator: frames local requests onto the link TX FIFO and parses
// response/ping frames from the RX FIFO. Optional OPB_EMU_PING_WAIT_EN gates REQ_READY on LINK_UP.
module opb_emu_initiator #(
   parameter int unsigned TIMEOUT_TICKS = 20
) (
   input  logic        SYS_CLK,
   input  logic        SYS_RST,
   input  logic        PULSE_2KHZ,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WR,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   output logic        RSP_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic        TX_FIFO_WR,
   output logic [7:0]  TX_FIFO_DATA,
   input  logic        TX_FIFO_FULL,
   output logic        RX_FIFO_RD,
   input  logic [7:0]  RX_FIFO_DATA,
   input  logic        RX_FIFO_EMPTY,
   output logic        LINK_UP,
   output logic        ERROR_FLAG
);

   typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_t;
   typedef enum logic [1:0] {RxHunt, RxType, RxPing, RxResp} rx_state_t;

   localparam logic [7:0] Sof        = 8'h5A;
   localparam logic [7:0] Eof        = 8'hA5;
   localparam logic [7:0] PingId     = 8'hAA;
   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_TICKS);

   state_t      state_q;
   logic [3:0]  tx_idx_q;
   logic        ready_q;
   logic        req_wr_q;
   logic [31:0] req_addr_q;
   logic [31:0] req_wdata_q;
   logic [7:0]  timer_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   rx_state_t   rx_state_q;
   logic [3:0]  rx_idx_q;
   logic        rx_pend_q;
   logic [7:0]  rx_cmd_q;
   logic [31:0] rx_addr_q;
   logic [31:0] rx_data_q;
   logic        link_up_q;
   logic        error_q;

   logic        link_ok;
   logic [7:0]  req_cmd;
   logic [7:0]  tx_byte;
   logic [7:0]  ping_exp;
   logic        rsp_hit;

`ifdef OPB_EMU_PING_WAIT_EN
   assign link_ok = link_up_q;
`else
   assign link_ok = 1'b1;
`endif

   assign req_cmd = req_wr_q ? 8'h01 : 8'h02;

   always_comb begin
      tx_byte = 8'h00;
      if (state_q == StSend) begin
         case (tx_idx_q)
            4'd0:    tx_byte = Sof;
            4'd1:    tx_byte = req_cmd;
            4'd2:    tx_byte = req_addr_q[31:24];
            4'd3:    tx_byte = req_addr_q[23:16];
            4'd4:    tx_byte = req_addr_q[15:8];
            4'd5:    tx_byte = req_addr_q[7:0];
            4'd6:    tx_byte = req_wdata_q[31:24];
            4'd7:    tx_byte = req_wdata_q[23:16];
            4'd8:    tx_byte = req_wdata_q[15:8];
            4'd9:    tx_byte = req_wdata_q[7:0];
            4'd10:   tx_byte = Eof;
            default: tx_byte = 8'h00;
         endcase
      end
   end

   always_comb begin
      case (rx_idx_q)
         4'd2:    ping_exp = 8'hBB;
         4'd3:    ping_exp = 8'hCC;
         4'd4:    ping_exp = 8'hDD;
         4'd5:    ping_exp = 8'h11;
         4'd6:    ping_exp = 8'h22;
         4'd7:    ping_exp = 8'h33;
         4'd8:    ping_exp = 8'h44;
         default: ping_exp = Eof;
      endcase
   end

   // Terminator of a response frame that matches the outstanding request.
   assign rsp_hit = rx_pend_q && (rx_state_q == RxResp) && (rx_idx_q == 4'd10) &&
                    (RX_FIFO_DATA == Eof) && (state_q == StWait) &&
                    (rx_cmd_q == (req_cmd | 8'h80)) && (rx_addr_q == req_addr_q);

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         state_q     <= StIdle;
         tx_idx_q    <= 4'd0;
         ready_q     <= 1'b0;
         req_wr_q    <= 1'b0;
         req_addr_q  <= 32'h0;
         req_wdata_q <= 32'h0;
         timer_q     <= 8'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (REQ_VALID && ready_q) begin
                  req_wr_q    <= REQ_WR;
                  req_addr_q  <= REQ_ADDR;
                  req_wdata_q <= REQ_WR ? REQ_WDATA : 32'h0;
                  tx_idx_q    <= 4'd0;
                  ready_q     <= 1'b0;
                  state_q     <= StSend;
               end else begin
                  ready_q <= link_ok;
               end
            end
            StSend: begin
               if (!TX_FIFO_FULL) begin
                  if (tx_idx_q == 4'd10) begin
                     timer_q <= 8'h0;
                     state_q <= StWait;
                  end else begin
                     tx_idx_q <= tx_idx_q + 4'd1;
                  end
               end
            end
            StWait: begin
               if (rsp_hit) begin
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= rx_data_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else if (timer_q >= TimeoutCnt) begin
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 32'h0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else if (PULSE_2KHZ && (timer_q != 8'hFF)) begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            StDone: begin
               ready_q <= link_ok;
               state_q <= StIdle;
            end
         endcase
      end
   end

   // A byte read this cycle appears on RX_FIFO_DATA next cycle, so reads alternate with processing.
   assign RX_FIFO_RD = !RX_FIFO_EMPTY && !rx_pend_q;

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         rx_state_q <= RxHunt;
         rx_idx_q   <= 4'd0;
         rx_pend_q  <= 1'b0;
         rx_cmd_q   <= 8'h0;
         rx_addr_q  <= 32'h0;
         rx_data_q  <= 32'h0;
         link_up_q  <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         rx_pend_q <= RX_FIFO_RD;
         if (rx_pend_q) begin
            unique case (rx_state_q)
               RxHunt: begin
                  if (RX_FIFO_DATA == Sof) rx_state_q <= RxType;
               end
               RxType: begin
                  rx_idx_q <= 4'd2;
                  if (RX_FIFO_DATA == PingId) begin
                     rx_state_q <= RxPing;
                  end else begin
                     rx_cmd_q   <= RX_FIFO_DATA;
                     rx_state_q <= RxResp;
                  end
               end
               RxPing: begin
                  if (RX_FIFO_DATA != ping_exp) begin
                     error_q    <= 1'b1;
                     rx_state_q <= RxHunt;
                  end else if (rx_idx_q == 4'd9) begin
                     link_up_q  <= 1'b1;
                     rx_state_q <= RxHunt;
                  end else begin
                     rx_idx_q <= rx_idx_q + 4'd1;
                  end
               end
               RxResp: begin
                  if (rx_idx_q == 4'd10) begin
                     rx_state_q <= RxHunt;
                     if ((RX_FIFO_DATA != Eof) || !rsp_hit) error_q <= 1'b1;
                  end else begin
                     rx_idx_q <= rx_idx_q + 4'd1;
                     if (rx_idx_q <= 4'd5) rx_addr_q <= {rx_addr_q[23:0], RX_FIFO_DATA};
                     else                  rx_data_q <= {rx_data_q[23:0], RX_FIFO_DATA};
                  end
               end
            endcase
         end
      end
   end

   assign REQ_READY    = ready_q;
   assign RSP_VALID    = rsp_valid_q;
   assign RSP_RDATA    = rsp_rdata_q;
   assign RSP_ERR      = rsp_err_q;
   assign TX_FIFO_WR   = (state_q == StSend) && !TX_FIFO_FULL;
   assign TX_FIFO_DATA = tx_byte;
   assign LINK_UP      = link_up_q;
   assign ERROR_FLAG   = error_q;

endmodule

// File: tb/tb_opb_emu_initiator.sv
// Bench for opb_emu_initiator: frame-level model of TX bytes and responses, RX FIFO model,
// directed scenarios for ping, write, read, timeout, TX back-pressure and framing errors.
module tb_opb_emu_initiator;

   logic        SYS_CLK = 1'b0;
   logic        SYS_RST;
   logic        PULSE_2KHZ;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WR;
   logic [31:0] REQ_ADDR;
   logic [31:0] REQ_WDATA;
   logic        RSP_VALID;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR;
   logic        TX_FIFO_WR;
   logic [7:0]  TX_FIFO_DATA;
   logic        TX_FIFO_FULL;
   logic        RX_FIFO_RD;
   logic [7:0]  RX_FIFO_DATA = 8'h00;
   logic        RX_FIFO_EMPTY;
   logic        LINK_UP;
   logic        ERROR_FLAG;

`ifdef OPB_EMU_PING_WAIT_EN
   localparam bit PingGate = 1'b1;
`else
   localparam bit PingGate = 1'b0;
`endif

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_tx[$];
   rsp_t        exp_rsp[$];
   logic [7:0]  tx_log[$];
   logic [7:0]  rx_mem[256];
   int          rx_wr = 0;
   int          rx_rd = 0;

   always #5 SYS_CLK = ~SYS_CLK;

   opb_emu_initiator #(.TIMEOUT_TICKS(20)) dut (
      .SYS_CLK       (SYS_CLK),
      .SYS_RST       (SYS_RST),
      .PULSE_2KHZ    (PULSE_2KHZ),
      .REQ_VALID     (REQ_VALID),
      .REQ_READY     (REQ_READY),
      .REQ_WR        (REQ_WR),
      .REQ_ADDR      (REQ_ADDR),
      .REQ_WDATA     (REQ_WDATA),
      .RSP_VALID     (RSP_VALID),
      .RSP_RDATA     (RSP_RDATA),
      .RSP_ERR       (RSP_ERR),
      .TX_FIFO_WR    (TX_FIFO_WR),
      .TX_FIFO_DATA  (TX_FIFO_DATA),
      .TX_FIFO_FULL  (TX_FIFO_FULL),
      .RX_FIFO_RD    (RX_FIFO_RD),
      .RX_FIFO_DATA  (RX_FIFO_DATA),
      .RX_FIFO_EMPTY (RX_FIFO_EMPTY),
      .LINK_UP       (LINK_UP),
      .ERROR_FLAG    (ERROR_FLAG)
   );

   // RX FIFO model: read data is presented the cycle after the read strobe.
   assign RX_FIFO_EMPTY = (rx_wr == rx_rd);
   always @(posedge SYS_CLK) begin
      if (RX_FIFO_RD && (rx_wr != rx_rd)) begin
         RX_FIFO_DATA <= rx_mem[rx_rd[7:0]];
         rx_rd        <= rx_rd + 1;
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail(string name, string info);
      checks++;
      errors++;
      $display("FAIL %s %s", name, info);
   endtask

   function automatic void model_request(bit wr, logic [31:0] a, logic [31:0] d);
      logic [31:0] dd;
      dd = wr ? d : 32'h0;
      exp_tx.push_back(8'h5A);
      exp_tx.push_back(wr ? 8'h01 : 8'h02);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(a[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(dd[i*8 +: 8]);
      exp_tx.push_back(8'hA5);
   endfunction

   task automatic rx_push(logic [7:0] b);
      rx_mem[rx_wr[7:0]] = b;
      rx_wr++;
   endtask

   task automatic rx_frame(logic [7:0] cmd, logic [31:0] a, logic [31:0] d);
      rx_push(8'h5A);
      rx_push(cmd);
      for (int i = 3; i >= 0; i--) rx_push(a[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) rx_push(d[i*8 +: 8]);
      rx_push(8'hA5);
   endtask

   task automatic rx_drain();
      int n = 0;
      while ((rx_wr != rx_rd) && (n < 500)) begin
         @(negedge SYS_CLK);
         n++;
      end
      if (rx_wr != rx_rd) fail("rx_drain", "RX FIFO not consumed within 500 cycles");
      repeat (4) @(negedge SYS_CLK);
   endtask

   task automatic wait_tx(string name);
      int n = 0;
      while ((exp_tx.size() != 0) && (n < 200)) begin
         @(negedge SYS_CLK);
         n++;
      end
      if (exp_tx.size() != 0) fail(name, $sformatf("%0d frame bytes never sent", exp_tx.size()));
      repeat (2) @(negedge SYS_CLK);
   endtask

   task automatic wait_rsp(string name);
      int n = 0;
      while ((exp_rsp.size() != 0) && (n < 200)) begin
         @(negedge SYS_CLK);
         n++;
      end
      if (exp_rsp.size() != 0) fail(name, "no RSP_VALID within 200 cycles");
      repeat (2) @(negedge SYS_CLK);
   endtask

   task automatic send_req(bit wr, logic [31:0] a, logic [31:0] d);
      int n = 0;
      model_request(wr, a, d);
      REQ_VALID = 1'b1;
      REQ_WR    = wr;
      REQ_ADDR  = a;
      REQ_WDATA = d;
      while (!REQ_READY && (n < 50)) begin
         @(negedge SYS_CLK);
         n++;
      end
      if (!REQ_READY) fail("req_accept", "REQ_READY never asserted");
      @(negedge SYS_CLK);
      REQ_VALID = 1'b0;
      if (!TX_FIFO_FULL) check("accept_to_first_tx", TX_FIFO_WR, 1);
   endtask

   task automatic pulse_ticks(int count);
      for (int i = 0; i < count; i++) begin
         PULSE_2KHZ = 1'b1;
         @(negedge SYS_CLK);
         PULSE_2KHZ = 1'b0;
         repeat (2) @(negedge SYS_CLK);
      end
   endtask

   task automatic do_reset();
      SYS_RST = 1'b1;
      repeat (3) @(negedge SYS_CLK);
   endtask

   task automatic compare_loop();
      logic prev_valid;
      logic prev_link;
      rsp_t r;
      prev_valid = 1'b0;
      prev_link  = 1'b0;
      forever begin
         @(negedge SYS_CLK);
         if (!SYS_RST) begin
            if (TX_FIFO_FULL) check("tx_wr_while_full", TX_FIFO_WR, 0);
            if (TX_FIFO_WR) begin
               tx_log.push_back(TX_FIFO_DATA);
               if (exp_tx.size() == 0) fail("tx_extra_byte", $sformatf("byte=%0h", TX_FIFO_DATA));
               else check("tx_byte", TX_FIFO_DATA, exp_tx.pop_front());
            end
            if (RSP_VALID) begin
               check("rsp_one_cycle", prev_valid, 0);
               if (exp_rsp.size() == 0) begin
                  fail("rsp_unexpected", $sformatf("err=%0b rdata=%0h", RSP_ERR, RSP_RDATA));
               end else begin
                  r = exp_rsp.pop_front();
                  check("rsp_err", RSP_ERR, r.err);
                  check("rsp_rdata", RSP_RDATA, r.rdata);
               end
            end
            if (prev_link) check("link_up_sticky", LINK_UP, 1);
            prev_valid = RSP_VALID;
            prev_link  = LINK_UP;
         end else begin
            prev_valid = 1'b0;
            prev_link  = 1'b0;
         end
      end
   endtask

   initial begin
      logic [7:0] lit_wr[11];
      lit_wr = '{8'h5A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5};
      SYS_RST      = 1'b1;
      PULSE_2KHZ   = 1'b0;
      REQ_VALID    = 1'b0;
      REQ_WR       = 1'b0;
      REQ_ADDR     = 32'h0;
      REQ_WDATA    = 32'h0;
      TX_FIFO_FULL = 1'b0;
      fork
         compare_loop();
      join_none
      repeat (3) @(negedge SYS_CLK);

      check("rst_req_ready", REQ_READY, 0);
      check("rst_rsp_valid", RSP_VALID, 0);
      check("rst_rsp_rdata", RSP_RDATA, 0);
      check("rst_rsp_err", RSP_ERR, 0);
      check("rst_tx_wr", TX_FIFO_WR, 0);
      check("rst_tx_data", TX_FIFO_DATA, 0);
      check("rst_rx_rd", RX_FIFO_RD, 0);
      check("rst_link_up", LINK_UP, 0);
      check("rst_error_flag", ERROR_FLAG, 0);
      SYS_RST = 1'b0;
      repeat (2) @(negedge SYS_CLK);
      check("idle_req_ready", REQ_READY, !PingGate);

      // Corrupted ping whose bad byte is 5A: it must not restart a frame.
      foreach (lit_wr[i]) begin end
      rx_push(8'h5A); rx_push(8'hAA); rx_push(8'hBB); rx_push(8'h5A); rx_push(8'hAA);
      rx_push(8'hBB); rx_push(8'hCC); rx_push(8'hDD); rx_push(8'h11); rx_push(8'h22);
      rx_push(8'h33); rx_push(8'h44); rx_push(8'hA5);
      rx_drain();
      check("bad_ping_error", ERROR_FLAG, 1);
      check("bad_ping_link", LINK_UP, 0);
      check("bad_ping_ready", REQ_READY, !PingGate);

      do_reset();
      SYS_RST = 1'b0;
      repeat (2) @(negedge SYS_CLK);
      check("reset_clears_error", ERROR_FLAG, 0);

      // Good ping: LINK_UP only after the terminator.
      rx_push(8'h5A); rx_push(8'hAA); rx_push(8'hBB); rx_push(8'hCC); rx_push(8'hDD);
      rx_push(8'h11); rx_push(8'h22); rx_push(8'h33); rx_push(8'h44);
      rx_drain();
      check("ping_no_eof_link", LINK_UP, 0);
      rx_push(8'hA5);
      rx_drain();
      check("ping_link_up", LINK_UP, 1);
      check("ping_error_flag", ERROR_FLAG, 0);
      check("ready_after_ping", REQ_READY, 1);

      // Write 0x10 <- DEADBEEF.
      tx_log.delete();
      send_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      wait_tx("write_tx");
      check("write_tx_len", tx_log.size(), 11);
      for (int i = 0; i < 11; i++) begin
         if (i < tx_log.size()) check($sformatf("write_tx_lit%0d", i), tx_log[i], lit_wr[i]);
      end
      check("wait_ready_low", REQ_READY, 0);
      exp_rsp.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
      rx_frame(8'h81, 32'h0000_0010, 32'hDEAD_BEEF);
      wait_rsp("write_rsp");
      check("write_ready_back", REQ_READY, 1);

      // Read 0x4; WDATA must not appear in the frame.
      send_req(1'b0, 32'h0000_0004, 32'hFFFF_FFFF);
      wait_tx("read_tx");
      exp_rsp.push_back('{err: 1'b0, rdata: 32'h1234_5678});
      rx_frame(8'h82, 32'h0000_0004, 32'h1234_5678);
      wait_rsp("read_rsp");
      check("read_rdata_lit", RSP_RDATA, 32'h1234_5678);
      check("read_err_lit", RSP_ERR, 0);

      // TX back-pressure mid-frame for 5 cycles.
      send_req(1'b1, 32'h0000_0020, 32'hCAFE_F00D);
      begin
         int n = 0;
         while ((exp_tx.size() > 7) && (n < 50)) begin
            @(negedge SYS_CLK);
            n++;
         end
      end
      @(posedge SYS_CLK);
      #1 TX_FIFO_FULL = 1'b1;
      repeat (5) @(posedge SYS_CLK);
      #1 TX_FIFO_FULL = 1'b0;
      wait_tx("full_tx");
      exp_rsp.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
      rx_frame(8'h81, 32'h0000_0020, 32'hCAFE_F00D);
      wait_rsp("full_rsp");
      check("clean_error_flag", ERROR_FLAG, 0);

      // Timeout, with a non-matching response dropped along the way.
      send_req(1'b0, 32'h0000_0008, 32'h0);
      wait_tx("timeout_tx");
      pulse_ticks(10);
      rx_frame(8'h82, 32'h0000_000C, 32'h0000_0BAD);
      rx_drain();
      check("mismatch_error_flag", ERROR_FLAG, 1);
      pulse_ticks(9);
      repeat (3) @(negedge SYS_CLK);
      check("tick19_still_waiting", REQ_READY, 0);
      exp_rsp.push_back('{err: 1'b1, rdata: 32'h0});
      pulse_ticks(1);
      wait_rsp("timeout_rsp");
      check("timeout_ready_back", REQ_READY, 1);
      check("timeout_err_lit", RSP_ERR, 1);

      repeat (5) @(negedge SYS_CLK);
      if (exp_tx.size() != 0) fail("tx_leftover", $sformatf("%0d bytes", exp_tx.size()));
      if (exp_rsp.size() != 0) fail("rsp_leftover", $sformatf("%0d responses", exp_rsp.size()));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
